fc_head: RTL and testbench

Classifier head downstream of `conv`. Consumes each finished 12×11 channel map from `conv` (`out_buff`/`out_valid`/`out_chan`), requantises every pixel to unsigned 8-bit and multiply-accumulates it against per-class fully-connected weights. After all CHAN channels of a frame have been absorbed, it runs an argmax over the class scores and reports the winning class with a one-cycle `done` pulse.

---
 rtl/fc_head.sv | 184 ++++++++++++++++++
 tb/tb_fc_head.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_head.sv
// Classifier head: requantises each conv channel map, accumulates per-class FC
// scores, then runs a sequential argmax once every channel of a frame is seen.
module fc_head #(
  parameter int unsigned OUT2_H  = 12,
  parameter int unsigned OUT2_W  = 11,
  parameter int unsigned CHAN    = 10,
  parameter int unsigned NUM_CLS = 4,
  parameter int unsigned SHIFT   = 4,
  parameter int unsigned ACC_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic signed [23:0]         in_map [0:OUT2_H-1][0:OUT2_W-1],
  input  logic                       in_valid,
  input  logic [3:0]                 in_chan,
  input  logic signed [7:0]          w_fc [0:NUM_CLS-1][0:CHAN-1][0:OUT2_H-1][0:OUT2_W-1],
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(NUM_CLS)-1:0] class_id,
  output logic signed [ACC_W-1:0]    scores [0:NUM_CLS-1],
  output logic                       err
);

  localparam int unsigned RW    = $clog2(OUT2_H);
  localparam int unsigned CW    = $clog2(OUT2_W);
  localparam int unsigned CLS_W = $clog2(NUM_CLS);

  typedef enum logic [1:0] {IDLE, ACCUM, ARGMAX, DONE} state_t;

  state_t                   state_q, state_d;
  logic                     in_valid_d_q;
  logic [RW-1:0]            row_q, row_d;
  logic [CW-1:0]            col_q, col_d;
  logic [3:0]               chan_q, chan_d;
  logic [CHAN-1:0]          seen_q, seen_d;
  logic [CLS_W-1:0]         arg_q, arg_d;
  logic [CLS_W-1:0]         best_idx_q, best_idx_d;
  logic signed [ACC_W-1:0]  best_val_q, best_val_d;
  logic [CLS_W-1:0]         class_id_q, class_id_d;
  logic signed [ACC_W-1:0]  scores_q [0:NUM_CLS-1];
  logic signed [ACC_W-1:0]  scores_d [0:NUM_CLS-1];
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     rise;
  logic [7:0]               q;
  logic signed [16:0]       qx;
  logic signed [16:0]       prod [0:NUM_CLS-1];

  // Negative pixels clamp to 0, large positives saturate at 255.
  function automatic logic [7:0] requant(input logic signed [23:0] v);
    logic signed [23:0] s;
    s = v >>> SHIFT;
    if (v[23])             return 8'd0;
    else if (s > 24'sd255) return 8'hFF;
    else                   return s[7:0];
  endfunction

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    chan_d     = chan_q;
    seen_d     = seen_q;
    arg_d      = arg_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    class_id_d = class_id_q;
    done_d     = 1'b0;
    err_d      = err_q;
    rise       = in_valid & ~in_valid_d_q;
    q          = requant(in_map[row_q][col_q]);
    qx         = 17'($signed({1'b0, q}));
    for (int n = 0; n < NUM_CLS; n++) begin
      scores_d[n] = scores_q[n];
      prod[n]     = qx * 17'(w_fc[n][chan_q][row_q][col_q]);
    end

    if (start) begin
      state_d    = IDLE;
      row_d      = '0;
      col_d      = '0;
      seen_d     = '0;
      arg_d      = '0;
      class_id_d = '0;
      err_d      = 1'b0;
      for (int n = 0; n < NUM_CLS; n++) scores_d[n] = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            if (32'(in_chan) >= CHAN) begin
              err_d = 1'b1;
            end else if (seen_q[in_chan]) begin
              err_d = 1'b1;
            end else begin
              chan_d  = in_chan;
              row_d   = '0;
              col_d   = '0;
              state_d = ACCUM;
            end
          end
        end
        ACCUM: begin
          for (int n = 0; n < NUM_CLS; n++)
            scores_d[n] = scores_q[n] + ACC_W'(prod[n]);
          if (col_q == CW'(OUT2_W - 1)) begin
            col_d = '0;
            if (row_q == RW'(OUT2_H - 1)) begin
              row_d  = '0;
              seen_d = seen_q | (CHAN'(1) << chan_q);
              if (&seen_d) begin
                state_d = ARGMAX;
                arg_d   = '0;
              end else begin
                state_d = IDLE;
              end
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
        ARGMAX: begin
          // Strict greater-than keeps the lowest index on ties.
          if (arg_q == CLS_W'(0) || scores_q[arg_q] > best_val_q) begin
            best_val_d = scores_q[arg_q];
            best_idx_d = arg_q;
          end
          if (arg_q == CLS_W'(NUM_CLS - 1)) begin
            state_d    = DONE;
            done_d     = 1'b1;
            class_id_d = best_idx_d;
          end else begin
            arg_d = arg_q + CLS_W'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
      if (rise && state_q != IDLE) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      in_valid_d_q <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      chan_q       <= '0;
      seen_q       <= '0;
      arg_q        <= '0;
      best_idx_q   <= '0;
      best_val_q   <= '0;
      class_id_q   <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      for (int n = 0; n < NUM_CLS; n++) scores_q[n] <= '0;
    end else begin
      state_q      <= state_d;
      in_valid_d_q <= in_valid;
      row_q        <= row_d;
      col_q        <= col_d;
      chan_q       <= chan_d;
      seen_q       <= seen_d;
      arg_q        <= arg_d;
      best_idx_q   <= best_idx_d;
      best_val_q   <= best_val_d;
      class_id_q   <= class_id_d;
      done_q       <= done_d;
      err_q        <= err_d;
      for (int n = 0; n < NUM_CLS; n++) scores_q[n] <= scores_d[n];
    end
  end

  assign busy     = (state_q == ACCUM) || (state_q == ARGMAX);
  assign done     = done_q;
  assign class_id = class_id_q;
  assign scores   = scores_q;
  assign err      = err_q;

endmodule

// File: tb/tb_fc_head.sv
// Randomised scoreboard bench for fc_head against a pixel-loop reference model.
module tb_fc_head;

  localparam int H = 12;
  localparam int W = 11;
  localparam int C = 10;
  localparam int K = 4;
  localparam int LAT = 136;  // done observed after posedge accept+136, i.e. sampled at accept+137

  typedef struct packed {
    logic [31:0]      cyc;
    logic [1:0]       cls;
    logic [3:0][31:0] sc;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start, in_valid;
  logic [3:0] in_chan;
  logic signed [23:0] in_map [0:H-1][0:W-1];
  logic signed [7:0]  w_fc [0:K-1][0:C-1][0:H-1][0:W-1];
  logic busy, done, err;
  logic [1:0] class_id;
  logic signed [31:0] scores [0:K-1];

  fc_head dut (
    .clk(clk), .rst(rst), .start(start), .in_map(in_map), .in_valid(in_valid),
    .in_chan(in_chan), .w_fc(w_fc), .busy(busy), .done(done),
    .class_id(class_id), .scores(scores), .err(err)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   m_sc [0:K-1];
  bit   m_seen [0:C-1];
  exp_t exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("done_latency", cyc, longint'(e.cyc));
        chk("class_id", class_id, e.cls);
        for (int n = 0; n < K; n++)
          chk($sformatf("score%0d", n), scores[n], longint'($signed(e.sc[n])));
      end
    end
  end

  function automatic int requant(input int v);
    int s;
    if (v < 0) return 0;
    s = v / 16;
    return (s > 255) ? 255 : s;
  endfunction

  function automatic int argmax();
    int best = 0;
    for (int n = 1; n < K; n++) if (m_sc[n] > m_sc[best]) best = n;
    return best;
  endfunction

  function automatic void model_clear();
    for (int n = 0; n < K; n++) m_sc[n] = 0;
    for (int c = 0; c < C; c++) m_seen[c] = 1'b0;
  endfunction

  function automatic void model_add(input int ch);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        for (int n = 0; n < K; n++)
          m_sc[n] += requant(int'(in_map[r][c])) * int'(w_fc[n][ch][r][c]);
  endfunction

  function automatic bit all_seen();
    for (int c = 0; c < C; c++) if (!m_seen[c]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic fill_map(input int v);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) in_map[r][c] = 24'(v);
  endtask

  task automatic rand_map();
    int v;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        case ($urandom_range(0, 3))
          0:       v = -int'($urandom_range(1, 100000));
          1:       v = int'($urandom_range(0, 4095));
          2:       v = int'($urandom_range(0, 8388607));
          default: v = 16 * int'($urandom_range(0, 300));
        endcase
        in_map[r][c] = 24'(v);
      end
  endtask

  task automatic set_w(input int cls, input int val);
    for (int ch = 0; ch < C; ch++)
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) w_fc[cls][ch][r][c] = 8'(val);
  endtask

  task automatic rand_w();
    for (int n = 0; n < K; n++) for (int ch = 0; ch < C; ch++)
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) w_fc[n][ch][r][c] = 8'($urandom);
  endtask

  // One in_valid pulse for channel ch; the model decides acceptance itself.
  task automatic send(input int ch, input int hold);
    exp_t e;
    @(negedge clk);
    in_chan  = 4'(ch);
    in_valid = 1'b1;
    if (ch < C) begin
      if (!m_seen[ch]) begin
        model_add(ch);
        m_seen[ch] = 1'b1;
        if (all_seen()) begin
          e.cyc = 32'(cyc + 1 + LAT);
          e.cls = 2'(argmax());
          for (int n = 0; n < K; n++) e.sc[n] = 32'(m_sc[n]);
          exp_q.push_back(e);
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (hold) @(negedge clk);
  endtask

  task automatic start_pulse(input bit with_edge);
    @(negedge clk);
    start = 1'b1;
    if (with_edge) begin
      in_valid = 1'b1;
      in_chan  = 4'd0;
    end
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    model_clear();
    chk("start_busy", busy, 0);
    chk("start_err", err, 0);
    chk("start_class", class_id, 0);
    for (int n = 0; n < K; n++) chk($sformatf("start_score%0d", n), scores[n], 0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      chk("done_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic chk_scores(input string name);
    for (int n = 0; n < K; n++) chk($sformatf("%s%0d", name, n), scores[n], m_sc[n]);
  endtask

  task automatic frame_in_order();
    for (int ch = 0; ch < C; ch++) send(ch, 132);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [0:C-1];
    int busy_cnt, dc, tmp, j;
    rst = 1'b1; start = 1'b0; in_valid = 1'b1; in_chan = 4'd0;
    fill_map(0);
    for (int n = 0; n < K; n++) set_w(n, 0);
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_class", class_id, 0);
    chk("rst_err", err, 0);
    for (int n = 0; n < K; n++) chk($sformatf("rst_score%0d", n), scores[n], 0);

    // Level-held in_valid: exactly one 132-cycle accumulation.
    rst = 1'b0;
    busy_cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    chk("held_valid_busy_cycles", busy_cnt, 132);
    in_valid = 1'b0;
    start_pulse(1'b0);

    // Single-class frame.
    fill_map(16);
    set_w(2, 1);
    frame_in_order();
    wait_done();
    chk("single_score2", scores[2], 1320);
    chk("single_class", class_id, 2);

    // Start with a simultaneous edge drops the edge.
    start_pulse(1'b1);
    repeat (3) @(negedge clk);
    chk("start_edge_busy", busy, 0);
    chk("start_edge_err", err, 0);

    // Requant corners through a single -3 weight.
    rand_w();
    for (int ch = 0; ch < C; ch++) begin
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) w_fc[0][ch][r][c] = 8'sd0;
      w_fc[0][ch][0][0] = -8'sd3;
    end
    rand_map(); in_map[0][0] = -24'sd5;   send(0, 132); chk("rq_neg", scores[0], 0);
    rand_map(); in_map[0][0] = 24'h000FFF; send(1, 132); chk("rq_sat", scores[0], -765);
    rand_map(); in_map[0][0] = 24'sd40;    send(2, 132); chk("rq_40", scores[0], -771);
    for (int ch = 3; ch < C; ch++) begin rand_map(); send(ch, 132); end
    wait_done();

    // Random frames, random channel order.
    for (int f = 0; f < 4; f++) begin
      start_pulse(1'b0);
      rand_w();
      for (int i = 0; i < C; i++) order[i] = i;
      for (int i = C - 1; i > 0; i--) begin
        j = int'($urandom_range(0, i));
        tmp = order[i]; order[i] = order[j]; order[j] = tmp;
      end
      for (int i = 0; i < C; i++) begin rand_map(); send(order[i], 132); end
      wait_done();
    end

    // Tie between classes 1 and 3.
    start_pulse(1'b0);
    fill_map(16);
    set_w(0, 0); set_w(1, 1); set_w(2, 0); set_w(3, 1);
    frame_in_order();
    wait_done();
    chk("tie_class", class_id, 1);

    // All-negative scores {-5,-2,-9,-7}.
    start_pulse(1'b0);
    for (int n = 0; n < K; n++) set_w(n, 0);
    w_fc[0][0][0][0] = -8'sd5; w_fc[1][0][0][0] = -8'sd2;
    w_fc[2][0][0][0] = -8'sd9; w_fc[3][0][0][0] = -8'sd7;
    fill_map(0); in_map[0][0] = 24'sd16;
    send(0, 132);
    fill_map(0);
    for (int ch = 1; ch < C; ch++) send(ch, 132);
    wait_done();
    chk("neg_class", class_id, 1);

    // Duplicate channel.
    start_pulse(1'b0);
    rand_w(); rand_map();
    send(4, 132);
    rand_map();
    send(4, 2);
    chk("dup_err", err, 1);
    chk("dup_busy", busy, 0);
    chk_scores("dup_score");

    // Out-of-range channel.
    start_pulse(1'b0);
    send(12, 2);
    chk("badchan_err", err, 1);
    chk("badchan_busy", busy, 0);

    // Overrun edge 50 cycles into ACCUM.
    start_pulse(1'b0);
    rand_map();
    send(0, 50);
    @(negedge clk); in_chan = 4'd1; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    chk("overrun_err", err, 1);
    repeat (90) @(negedge clk);
    chk("overrun_busy", busy, 0);
    chk_scores("overrun_score");

    // Missing channel: no done.
    start_pulse(1'b0);
    dc = done_cnt;
    for (int ch = 0; ch < C - 1; ch++) begin rand_map(); send(ch, 132); end
    repeat (300) @(negedge clk);
    chk("missing_no_done", done_cnt - dc, 0);

    // Start mid-frame clears err and scores, then a fresh frame completes.
    start_pulse(1'b0);
    rand_w();
    for (int ch = 0; ch < 6; ch++) begin rand_map(); send(ch, 132); end
    send(0, 2);
    chk("mid_dup_err", err, 1);
    rand_map();
    send(6, 20);
    chk("mid_busy_before", busy, 1);
    start_pulse(1'b0);
    rand_w();
    for (int ch = 0; ch < C; ch++) begin rand_map(); send(ch, 132); end
    wait_done();

    repeat (5) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
